dram_tx_streamer: RTL and testbench



---
 rtl/dram_tx_streamer_pkg.sv | 24 ++
 rtl/dram_tx_streamer_tx_done_edge.sv | 19 +
 rtl/dram_tx_streamer.sv | 141 ++++++++++++++
 tb/tb_dram_tx_streamer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_tx_streamer_pkg.sv
// Shared constants for the DRAM-to-UART byte streamer.
package dram_tx_streamer_pkg;

  localparam int unsigned DEF_ADDR_WIDTH   = 16;
  localparam int unsigned DEF_READ_LATENCY = 1;
  localparam int unsigned DEF_TX_TIMEOUT   = 1024;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned LAT_W   = 3;

  // FSM state encodings
  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH   = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_RD = 3'd2;
  localparam logic [STATE_W-1:0] ST_SEND    = 3'd3;
  localparam logic [STATE_W-1:0] ST_WAIT_TX = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE    = 3'd5;

  // Bits needed to hold any value in 0..max_val
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dram_tx_streamer_tx_done_edge.sv
// Rising-edge detector for the transmitter's sticky done level.
module tx_done_edge (
  input  logic clk,
  input  logic rstn,
  input  logic tx_done,
  output logic done_edge_c
);

  logic tx_done_q;

  // Previous-cycle copy of tx_done
  always_ff @(posedge clk) begin
    if (!rstn) tx_done_q <= 1'b0;
    else       tx_done_q <= tx_done;
  end

  assign done_edge_c = tx_done & ~tx_done_q;

endmodule

// File: rtl/dram_tx_streamer.sv
// Reads a block of bytes from DRAM and feeds them one at a time to the UART transmitter.
module dram_tx_streamer
  import dram_tx_streamer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned READ_LATENCY = DEF_READ_LATENCY,
  parameter int unsigned TX_TIMEOUT   = DEF_TX_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] byte_count,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic                  tx_start,
  output logic [7:0]            tx_data_byte,
  input  logic                  tx_done,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] bytes_sent
);

  localparam int unsigned TO_W = cnt_width(TX_TIMEOUT);

  logic [STATE_W-1:0]    state_q, state_d;
  logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [TO_W-1:0]       to_q, to_d, to_inc;
  logic [ADDR_WIDTH-1:0] mem_addr_d, bytes_sent_d;
  logic [7:0]            tx_data_byte_d;
  logic                  mem_rd_en_d, tx_start_d, busy_d, done_d, error_d;
  logic                  done_edge_c;

  tx_done_edge u_tx_done_edge (
    .clk         (clk),
    .rstn        (rstn),
    .tx_done     (tx_done),
    .done_edge_c (done_edge_c)
  );

  // Next-state and next-output decode
  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    lat_d          = lat_q;
    to_d           = to_q;
    to_inc         = to_q + TO_W'(1);
    mem_addr_d     = mem_addr;
    tx_data_byte_d = tx_data_byte;
    bytes_sent_d   = bytes_sent;
    busy_d         = busy;
    error_d        = error;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mem_addr_d   = base_addr;
          remaining_d  = byte_count;
          bytes_sent_d = '0;
          error_d      = 1'b0;
          busy_d       = 1'b1;
          state_d      = (byte_count == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        lat_d   = LAT_W'(READ_LATENCY);
        state_d = ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (lat_q == '0) begin
          tx_data_byte_d = mem_rdata;
          state_d        = ST_SEND;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ST_SEND: begin
        to_d    = '0;
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        to_d = to_inc;
        // A real completion wins over a timeout landing in the same cycle
        if (done_edge_c) begin
          bytes_sent_d = bytes_sent + ADDR_WIDTH'(1);
          mem_addr_d   = mem_addr + ADDR_WIDTH'(1);
          remaining_d  = remaining_q - ADDR_WIDTH'(1);
          state_d      = (remaining_q == ADDR_WIDTH'(1)) ? ST_DONE : ST_FETCH;
        end else if (to_inc == TO_W'(TX_TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes are high for the single cycle spent in their state
    mem_rd_en_d = (state_d == ST_FETCH);
    tx_start_d  = (state_d == ST_SEND);
    done_d      = (state_q == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      lat_q        <= '0;
      to_q         <= '0;
      mem_rd_en    <= 1'b0;
      mem_addr     <= '0;
      tx_start     <= 1'b0;
      tx_data_byte <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      bytes_sent   <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      lat_q        <= lat_d;
      to_q         <= to_d;
      mem_rd_en    <= mem_rd_en_d;
      mem_addr     <= mem_addr_d;
      tx_start     <= tx_start_d;
      tx_data_byte <= tx_data_byte_d;
      busy         <= busy_d;
      done         <= done_d;
      error        <= error_d;
      bytes_sent   <= bytes_sent_d;
    end
  end

endmodule

// File: tb/tb_dram_tx_streamer.sv
// Directed scoreboard bench: instance A (latency 1, UART model), instance B (latency 3, timeout 16).
module tb_dram_tx_streamer;

  localparam int CPB      = 4;
  localparam int B_RL     = 3;
  localparam int B_TX_CYC = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A ----------------
  logic        a_rstn = 1'b0, a_start = 1'b0;
  logic [15:0] a_base = '0, a_cnt = '0;
  logic        a_mem_rd_en, a_tx_start, a_busy, a_done, a_error;
  logic [15:0] a_mem_addr, a_bytes_sent;
  logic [7:0]  a_mem_rdata = '0, a_tx_data_byte;
  logic        a_tx_done = 1'b0;
  logic [7:0]  mem_a [0:65535];

  dram_tx_streamer #(.ADDR_WIDTH(16), .READ_LATENCY(1), .TX_TIMEOUT(1024)) u_dut_a (
    .clk(clk), .rstn(a_rstn), .start(a_start), .base_addr(a_base), .byte_count(a_cnt),
    .mem_rd_en(a_mem_rd_en), .mem_addr(a_mem_addr), .mem_rdata(a_mem_rdata),
    .tx_start(a_tx_start), .tx_data_byte(a_tx_data_byte), .tx_done(a_tx_done),
    .busy(a_busy), .done(a_done), .error(a_error), .bytes_sent(a_bytes_sent)
  );

  // DRAM A: one cycle read latency
  always @(posedge clk) if (a_mem_rd_en) a_mem_rdata <= mem_a[a_mem_addr];

  // UART transmitter model A (no reset, sticky done level)
  logic       a_tx_busy = 1'b0;
  logic [9:0] a_frame = '1;
  int         a_tk = 0, a_nb = 0;
  logic       a_ser;
  assign a_ser = a_tx_busy ? a_frame[0] : 1'b1;
  always @(posedge clk) begin
    if (a_tx_start) begin
      a_frame <= {1'b1, a_tx_data_byte, 1'b0};
      a_tk <= 0; a_nb <= 0; a_tx_busy <= 1'b1; a_tx_done <= 1'b0;
    end else if (a_tx_busy) begin
      if (a_tk == CPB - 1) begin
        a_tk <= 0;
        a_frame <= {1'b1, a_frame[9:1]};
        if (a_nb == 9) begin a_tx_busy <= 1'b0; a_tx_done <= 1'b1; end
        else a_nb <= a_nb + 1;
      end else a_tk <= a_tk + 1;
    end
  end

  // Serial line decoder (mid-bit sampling)
  logic       dec_act = 1'b0;
  int         dec_cnt = 0, dec_n = 0;
  logic [7:0] dec_sh = '0;
  int         a_obs_ser_q[$];
  always @(posedge clk) begin
    if (!dec_act) begin
      if (!a_ser) begin dec_act <= 1'b1; dec_cnt <= CPB + CPB / 2 - 1; dec_n <= 0; end
    end else if (dec_cnt != 0) dec_cnt <= dec_cnt - 1;
    else begin
      dec_cnt <= CPB - 1;
      if (dec_n < 8) begin dec_sh <= {a_ser, dec_sh[7:1]}; dec_n <= dec_n + 1; end
      else begin dec_act <= 1'b0; a_obs_ser_q.push_back(int'(dec_sh)); end
    end
  end

  int a_obs_addr_q[$], a_obs_byte_q[$], a_txs_cyc_q[$], a_done_cyc_q[$];
  always @(negedge clk) begin
    if (a_mem_rd_en) a_obs_addr_q.push_back(int'(a_mem_addr));
    if (a_tx_start) begin a_obs_byte_q.push_back(int'(a_tx_data_byte)); a_txs_cyc_q.push_back(cyc); end
    if (a_done) a_done_cyc_q.push_back(cyc);
  end

  // ---------------- instance B ----------------
  logic        b_rstn = 1'b0, b_start = 1'b0, b_stuck = 1'b0;
  logic [15:0] b_base = '0, b_cnt = '0;
  logic        b_mem_rd_en, b_tx_start, b_busy, b_done, b_error, b_tx_done;
  logic [15:0] b_mem_addr, b_bytes_sent;
  logic [7:0]  b_mem_rdata = '0, b_tx_data_byte;
  logic [7:0]  mem_b [0:65535];

  dram_tx_streamer #(.ADDR_WIDTH(16), .READ_LATENCY(B_RL), .TX_TIMEOUT(16)) u_dut_b (
    .clk(clk), .rstn(b_rstn), .start(b_start), .base_addr(b_base), .byte_count(b_cnt),
    .mem_rd_en(b_mem_rd_en), .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata),
    .tx_start(b_tx_start), .tx_data_byte(b_tx_data_byte), .tx_done(b_tx_done),
    .busy(b_busy), .done(b_done), .error(b_error), .bytes_sent(b_bytes_sent)
  );

  // DRAM B: three cycle read latency, data invalid in between
  int          b_rd_cnt = 0;
  logic [15:0] b_rd_addr = '0;
  always @(posedge clk) begin
    if (b_mem_rd_en) begin b_rd_cnt <= B_RL - 1; b_rd_addr <= b_mem_addr; b_mem_rdata <= 8'hxx; end
    else if (b_rd_cnt != 0) begin
      b_rd_cnt <= b_rd_cnt - 1;
      if (b_rd_cnt == 1) b_mem_rdata <= mem_b[b_rd_addr];
    end
  end

  // Transmitter model B: done level rises a fixed time after tx_start
  int   b_txc = 0;
  logic b_done_m = 1'b0;
  always @(posedge clk) begin
    if (b_tx_start) begin b_done_m <= 1'b0; b_txc <= B_TX_CYC; end
    else if (b_txc != 0) begin b_txc <= b_txc - 1; if (b_txc == 1) b_done_m <= 1'b1; end
  end
  assign b_tx_done = b_stuck | b_done_m;

  int b_obs_addr_q[$], b_obs_byte_q[$], b_txs_cyc_q[$], b_done_cyc_q[$];
  always @(negedge clk) begin
    if (b_mem_rd_en) b_obs_addr_q.push_back(int'(b_mem_addr));
    if (b_tx_start) begin b_obs_byte_q.push_back(int'(b_tx_data_byte)); b_txs_cyc_q.push_back(cyc); end
    if (b_done) b_done_cyc_q.push_back(cyc);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic cmp_list(input string tag, input int obs[$], input int exp[$], input int base);
    foreach (exp[i]) chk($sformatf("%s[%0d]", tag, i), 32'(qget(obs, base + i)), 32'(exp[i]));
    chk({tag, "_count"}, 32'(obs.size() - base), 32'(exp.size()));
  endtask

  task automatic a_pulse(input logic [15:0] base, input logic [15:0] cnt, output int s);
    @(posedge clk); #1;
    a_base = base; a_cnt = cnt; a_start = 1'b1; s = cyc;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic b_pulse(input logic [15:0] base, input logic [15:0] cnt, output int s);
    @(posedge clk); #1;
    b_base = base; b_cnt = cnt; b_start = 1'b1; s = cyc;
    @(posedge clk); #1;
    b_start = 1'b0;
  endtask

  task automatic a_wait_done(input int n0, input int budget, input string tag);
    int k = 0;
    while (a_done_cyc_q.size() <= n0 && k < budget) begin @(negedge clk); #1; k++; end
    chk({tag, "_done_seen"}, 32'(a_done_cyc_q.size() > n0), 32'd1);
  endtask

  task automatic b_wait_done(input int n0, input int budget, input string tag);
    int k = 0;
    while (b_done_cyc_q.size() <= n0 && k < budget) begin @(negedge clk); #1; k++; end
    chk({tag, "_done_seen"}, 32'(b_done_cyc_q.size() > n0), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  int s, ab, bb, sb, db, sb5;
  int exp_addr[$], exp_byte[$], exp_none[$];

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_error", 32'(a_error), 0);
    chk("rst_rd_en", 32'(a_mem_rd_en), 0);
    chk("rst_tx_start", 32'(a_tx_start), 0);
    chk("rst_addr", 32'(a_mem_addr), 0);
    chk("rst_bytes_sent", 32'(a_bytes_sent), 0);
    chk("rst_b_busy", 32'(b_busy), 0);
    @(posedge clk); #1;
    a_rstn = 1'b1; b_rstn = 1'b1;

    // T1: three bytes through the UART model
    mem_a[16'h0010] = 8'hA5; mem_a[16'h0011] = 8'h3C; mem_a[16'h0012] = 8'hFF;
    ab = a_obs_addr_q.size(); bb = a_obs_byte_q.size(); sb = a_obs_ser_q.size(); db = a_done_cyc_q.size();
    exp_addr = '{32'h10, 32'h11, 32'h12};
    exp_byte = '{32'hA5, 32'h3C, 32'hFF};
    a_pulse(16'h0010, 16'd3, s);
    a_wait_done(db, 1000, "t1");
    chk("t1_busy_low", 32'(a_busy), 0);
    chk("t1_bytes_sent", 32'(a_bytes_sent), 3);
    chk("t1_error", 32'(a_error), 0);
    chk("t1_first_txstart_lat", 32'(qget(a_txs_cyc_q, bb) - s), 4);
    cmp_list("t1_addr", a_obs_addr_q, exp_addr, ab);
    cmp_list("t1_byte", a_obs_byte_q, exp_byte, bb);
    repeat (5) @(negedge clk);
    #1;
    cmp_list("t1_serial", a_obs_ser_q, exp_byte, sb);
    chk("t1_done_pulses", 32'(a_done_cyc_q.size() - db), 1);

    // T2: zero-length block
    ab = a_obs_addr_q.size(); bb = a_obs_byte_q.size(); db = a_done_cyc_q.size();
    a_pulse(16'h0100, 16'd0, s);
    a_wait_done(db, 20, "t2");
    chk("t2_done_lat", 32'(qget(a_done_cyc_q, db) - s), 2);
    chk("t2_bytes_sent", 32'(a_bytes_sent), 0);
    chk("t2_busy_low", 32'(a_busy), 0);
    cmp_list("t2_addr", a_obs_addr_q, exp_none, ab);
    cmp_list("t2_byte", a_obs_byte_q, exp_none, bb);

    // T3: address wrap at the top of memory
    mem_a[16'hFFFF] = 8'h11; mem_a[16'h0000] = 8'h22;
    ab = a_obs_addr_q.size(); bb = a_obs_byte_q.size(); db = a_done_cyc_q.size();
    exp_addr = '{32'hFFFF, 32'h0000};
    exp_byte = '{32'h11, 32'h22};
    a_pulse(16'hFFFF, 16'd2, s);
    a_wait_done(db, 1000, "t3");
    cmp_list("t3_addr", a_obs_addr_q, exp_addr, ab);
    cmp_list("t3_byte", a_obs_byte_q, exp_byte, bb);
    chk("t3_bytes_sent", 32'(a_bytes_sent), 2);
    repeat (5) @(negedge clk);

    // T5: repeat start while busy, then reset during WAIT_TX, then a fresh block
    mem_a[16'h0020] = 8'h5A; mem_a[16'h0021] = 8'hC3; mem_a[16'h0022] = 8'h81;
    mem_a[16'h0030] = 8'h96; mem_a[16'h0031] = 8'h69; mem_a[16'h0040] = 8'hEE;
    ab = a_obs_addr_q.size(); bb = a_obs_byte_q.size(); sb5 = a_obs_ser_q.size(); db = a_done_cyc_q.size();
    a_pulse(16'h0020, 16'd3, s);
    repeat (8) @(posedge clk);
    a_pulse(16'h0040, 16'd1, s);
    repeat (4) @(posedge clk);
    #1 a_rstn = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    chk("t5_rst_busy", 32'(a_busy), 0);
    chk("t5_rst_tx_start", 32'(a_tx_start), 0);
    chk("t5_rst_addr", 32'(a_mem_addr), 0);
    chk("t5_rst_data", 32'(a_tx_data_byte), 0);
    chk("t5_rst_bytes_sent", 32'(a_bytes_sent), 0);
    chk("t5_rst_error", 32'(a_error), 0);
    repeat (60) @(posedge clk);
    #1 a_rstn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("t5_no_done_pulse", 32'(a_done_cyc_q.size() - db), 0);
    exp_addr = '{32'h20};
    exp_byte = '{32'h5A};
    cmp_list("t5_abort_addr", a_obs_addr_q, exp_addr, ab);
    cmp_list("t5_abort_byte", a_obs_byte_q, exp_byte, bb);
    ab = a_obs_addr_q.size(); bb = a_obs_byte_q.size(); db = a_done_cyc_q.size();
    exp_addr = '{32'h30, 32'h31};
    exp_byte = '{32'h96, 32'h69};
    a_pulse(16'h0030, 16'd2, s);
    a_wait_done(db, 1000, "t5");
    cmp_list("t5_addr", a_obs_addr_q, exp_addr, ab);
    cmp_list("t5_byte", a_obs_byte_q, exp_byte, bb);
    chk("t5_bytes_sent", 32'(a_bytes_sent), 2);
    chk("t5_error", 32'(a_error), 0);
    repeat (5) @(negedge clk);
    #1;
    exp_byte = '{32'h5A, 32'h96, 32'h69};
    cmp_list("t5_serial", a_obs_ser_q, exp_byte, sb5);

    // T6: read latency 3
    mem_b[16'h0100] = 8'h3E; mem_b[16'h0101] = 8'hD7;
    ab = b_obs_addr_q.size(); bb = b_obs_byte_q.size(); db = b_done_cyc_q.size();
    exp_addr = '{32'h100, 32'h101};
    exp_byte = '{32'h3E, 32'hD7};
    b_pulse(16'h0100, 16'd2, s);
    b_wait_done(db, 200, "t6");
    chk("t6_first_txstart_lat", 32'(qget(b_txs_cyc_q, bb) - s), 6);
    cmp_list("t6_addr", b_obs_addr_q, exp_addr, ab);
    cmp_list("t6_byte", b_obs_byte_q, exp_byte, bb);
    chk("t6_bytes_sent", 32'(b_bytes_sent), 2);
    chk("t6_error", 32'(b_error), 0);

    // T4: tx_done stuck high -> timeout
    mem_b[16'h0200] = 8'h77;
    @(posedge clk); #1 b_stuck = 1'b1;
    repeat (3) @(posedge clk);
    ab = b_obs_addr_q.size(); bb = b_obs_byte_q.size(); db = b_done_cyc_q.size();
    exp_addr = '{32'h200};
    exp_byte = '{32'h77};
    b_pulse(16'h0200, 16'd1, s);
    b_wait_done(db, 200, "t4");
    chk("t4_timeout_lat", 32'(qget(b_done_cyc_q, db) - qget(b_txs_cyc_q, bb)), 17);
    chk("t4_error", 32'(b_error), 1);
    chk("t4_bytes_sent", 32'(b_bytes_sent), 0);
    chk("t4_busy_low", 32'(b_busy), 0);
    cmp_list("t4_addr", b_obs_addr_q, exp_addr, ab);
    cmp_list("t4_byte", b_obs_byte_q, exp_byte, bb);
    repeat (3) @(posedge clk);
    chk("t4_error_sticky", 32'(b_error), 1);
    #1 b_stuck = 1'b0;

    // Error cleared by the next accepted start
    db = b_done_cyc_q.size();
    b_pulse(16'h0000, 16'd0, s);
    b_wait_done(db, 20, "t4b");
    chk("t4b_error_cleared", 32'(b_error), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
